// File: rtl/nios2_pio_edge_in.sv
// nios2_pio_edge_in: Avalon-MM input PIO with per-bit synchroniser,
// debounce, selectable edge capture and maskable level interrupt.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     register word address: 0 data, 1 reserved,
//               2 irq_mask, 3 edge_capture (write-1-to-clear)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data; bits at or above WIDTH are ignored
//   in_port     asynchronous external inputs
//   readdata    registered read data, one cycle after address
//   irq         level interrupt, |(edge_capture & irq_mask)
module nios2_pio_edge_in #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int EDGE_MODE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_d;
   logic [CW-1:0]    cnt [WIDTH];
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] ev;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] w1c;
   logic             wr_en;
   logic             mask_we;
   logic [31:0]      rd_mux;

   // Upper writedata bits have no register behind them.
   if (WIDTH < 32) begin : g_wd_hi
      logic unused_wd_hi;
      assign unused_wd_hi = ^writedata[31:WIDTH];
   end

   // Synchroniser chain: stage 0 samples the raw pins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // Debounce: count consecutive cycles where the synchronised bit
   // disagrees with the debounced bit; accept the new level once the
   // disagreement has lasted DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= sync[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // Edge detection on the debounced value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_d <= '0;
      end else begin
         deb_d <= deb;
      end
   end

   assign rise = deb & ~deb_d;
   assign fall = ~deb & deb_d;

   always_comb begin
      ev = rise;
      if (EDGE_MODE == 1) begin
         ev = fall;
      end else if (EDGE_MODE == 2) begin
         ev = rise | fall;
      end
   end

   // Bus write decode.
   assign wr_en   = chipselect & ~write_n;
   assign mask_we = wr_en && (address == ADDR_MASK);
   assign w1c     = (wr_en && (address == ADDR_EDGE))
                  ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_mask <= '0;
      end else if (mask_we) begin
         irq_mask <= writedata[WIDTH-1:0];
      end
   end

   // A new edge outranks a clear arriving on the same clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_capture <= '0;
      end else begin
         edge_capture <= ev | (edge_capture & ~w1c);
      end
   end

   // Read mux, registered every clock; reads have no side effects.
   always_comb begin
      rd_mux = '0;
      unique case (address)
         ADDR_DATA: rd_mux = 32'(deb);
         ADDR_RSVD: rd_mux = '0;
         ADDR_MASK: rd_mux = 32'(irq_mask);
         ADDR_EDGE: rd_mux = 32'(edge_capture);
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

   assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios2_pio_edge_in.sv
// tb_nios2_pio_edge_in: directed vectors plus randomised traffic on three
// configurations of nios2_pio_edge_in, checked against a history model.
module tb_nios2_pio_edge_in;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] inp [NI];

   logic [7:0]  in0;
   logic [7:0]  in1;
   logic [31:0] in2;
   logic [31:0] rd0;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        irq0;
   logic        irq1;
   logic        irq2;

   int n_run  = 0;
   int n_fail = 0;

   assign in0 = inp[0][7:0];
   assign in1 = inp[1][7:0];
   assign in2 = inp[2];

   always #5 clk = ~clk;

   nios2_pio_edge_in #(
      .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)
   ) u0 (
      .clk(clk), .reset(reset), .address(address),
      .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in0),
      .readdata(rd0), .irq(irq0)
   );

   nios2_pio_edge_in #(
      .WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EDGE_MODE(1)
   ) u1 (
      .clk(clk), .reset(reset), .address(address),
      .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in1),
      .readdata(rd1), .irq(irq1)
   );

   nios2_pio_edge_in #(
      .WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(2), .EDGE_MODE(2)
   ) u2 (
      .clk(clk), .reset(reset), .address(address),
      .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in2),
      .readdata(rd2), .irq(irq2)
   );

   function automatic int pw(input int i);
      return (i == 2) ? 32 : 8;
   endfunction

   function automatic int ps(input int i);
      return (i == 1) ? 3 : 2;
   endfunction

   function automatic int pd(input int i);
      if (i == 0) return 4;
      if (i == 1) return 1;
      return 2;
   endfunction

   function automatic int pm(input int i);
      return i;
   endfunction

   function automatic logic [31:0] wmask(input int i);
      if (pw(i) == 32) return 32'hFFFF_FFFF;
      return (32'h1 << pw(i)) - 32'h1;
   endfunction

   function automatic logic [31:0] rd_of(input int i);
      if (i == 0) return rd0;
      if (i == 1) return rd1;
      return rd2;
   endfunction

   function automatic logic irq_of(input int i);
      if (i == 0) return irq0;
      if (i == 1) return irq1;
      return irq2;
   endfunction

   // Reference model: keeps the raw sample history of in_port and of the
   // debounced value, and derives each register from those histories.
   logic [31:0] m_hist [NI][16];
   logic [31:0] m_dh   [NI][16];
   logic [31:0] m_ec   [NI];
   logic [31:0] m_mask [NI];
   logic [31:0] m_rd   [NI];
   int          m_k;

   task automatic model_reset();
      m_k = 0;
      for (int i = 0; i < NI; i++) begin
         for (int j = 0; j < 16; j++) begin
            m_hist[i][j] = '0;
            m_dh[i][j]   = '0;
         end
         m_ec[i]   = '0;
         m_mask[i] = '0;
         m_rd[i]   = '0;
      end
   endtask

   task automatic model_step();
      logic        wr;
      logic [31:0] deb_o;
      logic [31:0] prev2;
      logic [31:0] deb_n;
      logic [31:0] rise;
      logic [31:0] fall;
      logic [31:0] ev;
      logic [31:0] clr;
      logic [31:0] wm;
      bit          flip;
      m_k++;
      wr = chipselect && !write_n;
      for (int i = 0; i < NI; i++) begin
         wm = wmask(i);
         m_hist[i][m_k & 15] = inp[i] & wm;
         deb_o = m_dh[i][(m_k - 1) & 15];
         prev2 = m_dh[i][(m_k - 2) & 15];
         deb_n = deb_o;
         // A bit flips once the last D synchronised samples all differ.
         for (int b = 0; b < pw(i); b++) begin
            flip = 1'b1;
            for (int j = 0; j < pd(i); j++) begin
               if (m_hist[i][(m_k - ps(i) - j) & 15][b] == deb_o[b])
                  flip = 1'b0;
            end
            if (flip) deb_n[b] = ~deb_o[b];
         end
         m_dh[i][m_k & 15] = deb_n;
         rise = deb_o & ~prev2;
         fall = ~deb_o & prev2;
         if (pm(i) == 0)      ev = rise;
         else if (pm(i) == 1) ev = fall;
         else                 ev = rise | fall;
         case (address)
            2'd0:    m_rd[i] = deb_o;
            2'd2:    m_rd[i] = m_mask[i];
            2'd3:    m_rd[i] = m_ec[i];
            default: m_rd[i] = '0;
         endcase
         clr = (wr && address == 2'd3) ? (writedata & wm) : '0;
         m_ec[i] = ev | (m_ec[i] & ~clr);
         if (wr && address == 2'd2) m_mask[i] = writedata & wm;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("model u%0d rd", i), rd_of(i), m_rd[i]);
         chk($sformatf("model u%0d irq", i), 32'(irq_of(i)),
             32'(|(m_ec[i] & m_mask[i])));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!reset) model_step();
      @(negedge clk);
      check_model();
   endtask

   typedef struct {
      logic [7:0]  din;
      logic [1:0]  addr;
      logic        wr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        irq;
   } vec_t;

   vec_t tv[$];

   function automatic void add(input logic [7:0] d, input logic [1:0] a,
                               input logic w, input logic [31:0] wd,
                               input logic [31:0] rd, input logic q);
      vec_t v;
      v.din  = d;
      v.addr = a;
      v.wr   = w;
      v.wd   = wd;
      v.rd   = rd;
      v.irq  = q;
      tv.push_back(v);
   endfunction

   initial begin
      // Directed vectors for u0 (rising, 2 sync, 4 debounce).
      add(8'h00, 2'd0, 1'b0, 32'h0, 32'h00, 1'b0);
      add(8'h00, 2'd2, 1'b1, 32'h1, 32'h00, 1'b0);
      add(8'h00, 2'd2, 1'b0, 32'h0, 32'h01, 1'b0);
      add(8'h00, 2'd1, 1'b0, 32'h0, 32'h00, 1'b0);
      for (int k = 0; k < 5; k++) add(8'h01, 2'd3, 1'b0, 32'h0, 32'h00, 1'b0);
      add(8'h01, 2'd0, 1'b0, 32'h0, 32'h00, 1'b0);
      add(8'h01, 2'd0, 1'b0, 32'h0, 32'h01, 1'b1);
      add(8'h01, 2'd3, 1'b0, 32'h0, 32'h01, 1'b1);
      add(8'h01, 2'd3, 1'b1, 32'h1, 32'h01, 1'b0);
      add(8'h01, 2'd3, 1'b0, 32'h0, 32'h00, 1'b0);
      add(8'h01, 2'd0, 1'b0, 32'h0, 32'h01, 1'b0);
      for (int k = 0; k < 3; k++) add(8'h09, 2'd0, 1'b0, 32'h0, 32'h01, 1'b0);
      for (int k = 0; k < 7; k++) begin
         if (k % 2 == 0) add(8'h01, 2'd3, 1'b0, 32'h0, 32'h00, 1'b0);
         else            add(8'h01, 2'd0, 1'b0, 32'h0, 32'h01, 1'b0);
      end
      for (int k = 0; k < 6; k++) add(8'h09, 2'd0, 1'b0, 32'h0, 32'h01, 1'b0);
      add(8'h01, 2'd0, 1'b0, 32'h0, 32'h09, 1'b0);
      add(8'h01, 2'd3, 1'b0, 32'h0, 32'h08, 1'b0);
      for (int k = 0; k < 4; k++) add(8'h01, 2'd0, 1'b0, 32'h0, 32'h09, 1'b0);
      add(8'h01, 2'd0, 1'b0, 32'h0, 32'h01, 1'b0);
      add(8'h01, 2'd3, 1'b0, 32'h0, 32'h08, 1'b0);
      add(8'h01, 2'd2, 1'b1, 32'h4, 32'h01, 1'b0);
      add(8'h05, 2'd2, 1'b0, 32'h0, 32'h04, 1'b0);
      for (int k = 0; k < 5; k++) add(8'h05, 2'd0, 1'b0, 32'h0, 32'h01, 1'b0);
      add(8'h05, 2'd3, 1'b1, 32'h4, 32'h08, 1'b1);
      add(8'h05, 2'd3, 1'b0, 32'h0, 32'h0C, 1'b1);
      add(8'h05, 2'd0, 1'b0, 32'h0, 32'h05, 1'b1);
      add(8'h05, 2'd2, 1'b1, 32'hF0, 32'h04, 1'b0);
      add(8'h05, 2'd2, 1'b1, 32'h08, 32'hF0, 1'b1);
      add(8'h05, 2'd2, 1'b0, 32'h0, 32'h08, 1'b1);
      add(8'h05, 2'd3, 1'b1, 32'hFF, 32'h0C, 1'b0);
      add(8'h05, 2'd3, 1'b0, 32'h0, 32'h00, 1'b0);
      add(8'h05, 2'd0, 1'b1, 32'hFF, 32'h05, 1'b0);
      add(8'h05, 2'd1, 1'b1, 32'hFF, 32'h00, 1'b0);
      add(8'h05, 2'd0, 1'b0, 32'h0, 32'h05, 1'b0);
      add(8'h05, 2'd2, 1'b1, 32'hFFFF_FFFF, 32'h08, 1'b0);
      add(8'h05, 2'd2, 1'b0, 32'h0, 32'hFF, 1'b0);
      add(8'h05, 2'd2, 1'b1, 32'h0, 32'hFF, 1'b0);

      reset      = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      for (int i = 0; i < NI; i++) inp[i] = '0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;

      foreach (tv[r]) begin
         inp[0]     = {24'h0, tv[r].din};
         address    = tv[r].addr;
         chipselect = tv[r].wr;
         write_n    = ~tv[r].wr;
         writedata  = tv[r].wd;
         cycle();
         chk($sformatf("vec%0d rd", r), rd0, tv[r].rd);
         chk($sformatf("vec%0d irq", r), 32'(irq0), 32'(tv[r].irq));
      end

      // Randomised traffic; slow-toggling pins so debounce both passes
      // and rejects.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NI; i++) begin
            for (int b = 0; b < pw(i); b++) begin
               if ($urandom_range(7) == 0) inp[i][b] = ~inp[i][b];
            end
         end
         chipselect = 1'($urandom_range(1));
         write_n    = ($urandom_range(2) != 0);
         address    = 2'($urandom_range(3));
         writedata  = $urandom;
         cycle();
      end

      // Asynchronous reset in the middle of a cycle.
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("arst rd0", rd0, 32'h0);
      chk("arst rd1", rd1, 32'h0);
      chk("arst rd2", rd2, 32'h0);
      chk("arst irq", 32'({irq0, irq1, irq2}), 32'h0);
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd3;
      for (int i = 0; i < NI; i++) inp[i] = 32'hFFFF_FFFF;
      cycle();
      cycle();
      reset = 1'b0;

      // Pins high at release count as rising edges.
      repeat (20) cycle();
      chk("rel rise u0", rd0, 32'h0000_00FF);
      chk("rel rise u1", rd1, 32'h0000_0000);
      chk("rel rise u2", rd2, 32'hFFFF_FFFF);
      chk("rel irq", 32'({irq0, irq1, irq2}), 32'h0);

      // Falling edges: only falling/any modes react; flags stay sticky.
      for (int i = 0; i < NI; i++) inp[i] = '0;
      repeat (20) cycle();
      chk("fall u0", rd0, 32'h0000_00FF);
      chk("fall u1", rd1, 32'h0000_00FF);
      chk("fall u2", rd2, 32'hFFFF_FFFF);
      address = 2'd0;
      cycle();
      chk("data u0", rd0, 32'h0);
      chk("data u2", rd2, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
